// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ALU operation sequencer:
//                opcode constants, FSM state encoding and the field offsets
//                of a FIFO_IN entry {op, data1, data0}.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_STORE = 3'd5
    } seq_state_t;

    // data0 sits in the low bits, data1 above it, the opcode on top.
    localparam int DATA0_LSB = 0;

    function automatic int data1_lsb(input int data_width);
        return data_width;
    endfunction

    function automatic int op_lsb(input int data_width);
        return 2 * data_width;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/seq_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : seq_timeout_cnt
//  Description : Cycle counter bounding how long the sequencer waits for the
//                ALU. Cleared by 'clear', advances while 'enable' is high;
//                'expired' flags the final allowed cycle (count == LIMIT-1).
//  Ports       : clk, rst_n (sync, active-low), clear, enable -> expired
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_timeout_cnt #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int c_cnt_w = $clog2(LIMIT);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == c_cnt_w'(LIMIT - 1));

endmodule : seq_timeout_cnt
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Pops one {op, data1, data0} entry from FIFO_IN, issues it to
//                the ALU with a start/done handshake, and pushes {err, result}
//                into FIFO_OUT. Illegal opcodes and ALU timeouts produce an
//                error entry {1, 0}; a timeout also sets sticky err_timeout.
//  Ports       : clk, rst_n, enable, err_clr        - clock/reset/CSR control
//                fifo_in_empty/rdata/r_en           - FIFO_IN read side
//                alu_start/op/a/b, alu_done/result  - ALU handshake
//                fifo_out_full/w_en/wdata           - FIFO_OUT write side
//                busy, err_timeout                  - status
//                ops_done[15:0]                     - only with ALU_SEQ_PERF_CNT_EN
//  Options     : `define ALU_SEQ_PERF_CNT_EN adds the completed-ops counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH     = 12,
    parameter int OPERATION_SIZE = 2,
    parameter int FIFO_IN_WIDTH  = 26,
    parameter int FIFO_OUT_WIDTH = 25,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      err_clr,
    input  logic                      fifo_in_empty,
    input  logic [FIFO_IN_WIDTH-1:0]  fifo_in_rdata,
    output logic                      fifo_in_r_en,
    output logic                      alu_start,
    output logic [OPERATION_SIZE-1:0] alu_op,
    output logic [DATA_WIDTH-1:0]     alu_a,
    output logic [DATA_WIDTH-1:0]     alu_b,
    input  logic                      alu_done,
    input  logic [2*DATA_WIDTH-1:0]   alu_result,
    input  logic                      fifo_out_full,
    output logic                      fifo_out_w_en,
    output logic [FIFO_OUT_WIDTH-1:0] fifo_out_wdata,
`ifdef ALU_SEQ_PERF_CNT_EN
    output logic [15:0]               ops_done,
`endif
    output logic                      busy,
    output logic                      err_timeout
);

    localparam int c_d1_lsb = data1_lsb(DATA_WIDTH);
    localparam int c_op_lsb = op_lsb(DATA_WIDTH);

    seq_state_t r_state;
    seq_state_t w_next_state;

    logic [OPERATION_SIZE-1:0] r_op;
    logic [DATA_WIDTH-1:0]     r_a;
    logic [DATA_WIDTH-1:0]     r_b;
    logic [FIFO_OUT_WIDTH-1:0] r_wdata;
    logic                      r_err;

    logic w_op_legal;
    logic w_load;
    logic w_wr_ok;
    logic w_wr_err;
    logic w_timeout;
    logic w_cnt_clear;
    logic w_cnt_en;
    logic w_expired;

    assign w_op_legal = (r_op == OPERATION_SIZE'(OP_ADD)) ||
                        (r_op == OPERATION_SIZE'(OP_MUL));

    seq_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_cnt_clear),
        .enable  (w_cnt_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        fifo_in_r_en  = 1'b0;
        alu_start     = 1'b0;
        fifo_out_w_en = 1'b0;
        w_load        = 1'b0;
        w_wr_ok       = 1'b0;
        w_wr_err      = 1'b0;
        w_timeout     = 1'b0;
        w_cnt_clear   = 1'b0;
        w_cnt_en      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && !fifo_in_empty) begin
                    w_next_state = ST_POP;
                end
            end
            ST_POP: begin
                fifo_in_r_en = 1'b1;
                w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                // FIFO read data is valid the cycle after the pop pulse.
                w_load       = 1'b1;
                w_next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (w_op_legal) begin
                    alu_start    = 1'b1;
                    w_cnt_clear  = 1'b1;
                    w_next_state = ST_WAIT;
                end else begin
                    w_wr_err     = 1'b1;
                    w_next_state = ST_STORE;
                end
            end
            ST_WAIT: begin
                w_cnt_en = 1'b1;
                // A done arriving on the last allowed cycle beats the timeout.
                if (alu_done) begin
                    w_wr_ok      = 1'b1;
                    w_next_state = ST_STORE;
                end else if (w_expired) begin
                    w_wr_err     = 1'b1;
                    w_timeout    = 1'b1;
                    w_next_state = ST_STORE;
                end
            end
            ST_STORE: begin
                if (!fifo_out_full) begin
                    fifo_out_w_en = 1'b1;
                    w_next_state  = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_load) begin
                r_op <= fifo_in_rdata[c_op_lsb +: OPERATION_SIZE];
                r_b  <= fifo_in_rdata[c_d1_lsb +: DATA_WIDTH];
                r_a  <= fifo_in_rdata[DATA0_LSB +: DATA_WIDTH];
            end
            if (w_wr_ok) begin
                r_wdata <= {1'b0, alu_result};
            end else if (w_wr_err) begin
                r_wdata <= {1'b1, {(2*DATA_WIDTH){1'b0}}};
            end
            // A timeout landing together with err_clr keeps the flag set.
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_PERF_CNT_EN
    logic [15:0] r_ops_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ops_done <= '0;
        end else if (err_clr) begin
            r_ops_done <= '0;
        end else if (fifo_out_w_en) begin
            r_ops_done <= r_ops_done + 16'd1;
        end
    end

    assign ops_done = r_ops_done;
`endif

    assign alu_op         = r_op;
    assign alu_a          = r_a;
    assign alu_b          = r_b;
    assign fifo_out_wdata = r_wdata;
    assign err_timeout    = r_err;
    assign busy           = (r_state != ST_IDLE);

endmodule : alu_op_sequencer
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Directed self-checking bench for alu_op_sequencer with a
//                small FIFO_IN model, a delay-programmable ALU model and
//                handshake monitors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam int DW  = 12;
    localparam int OPS = 2;
    localparam int FIW = 26;
    localparam int FOW = 25;
    localparam int TO  = 16;

    logic            clk;
    logic            rst_n;
    logic            enable;
    logic            err_clr;
    logic            fifo_in_empty;
    logic [FIW-1:0]  fifo_in_rdata;
    logic            fifo_in_r_en;
    logic            alu_start;
    logic [OPS-1:0]  alu_op;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic            alu_done;
    logic [2*DW-1:0] alu_result;
    logic            fifo_out_full;
    logic            fifo_out_w_en;
    logic [FOW-1:0]  fifo_out_wdata;
    logic            busy;
    logic            err_timeout;
`ifdef ALU_SEQ_PERF_CNT_EN
    logic [15:0]     ops_done;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_op_sequencer #(
        .DATA_WIDTH     (DW),
        .OPERATION_SIZE (OPS),
        .FIFO_IN_WIDTH  (FIW),
        .FIFO_OUT_WIDTH (FOW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .err_clr        (err_clr),
        .fifo_in_empty  (fifo_in_empty),
        .fifo_in_rdata  (fifo_in_rdata),
        .fifo_in_r_en   (fifo_in_r_en),
        .alu_start      (alu_start),
        .alu_op         (alu_op),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_done       (alu_done),
        .alu_result     (alu_result),
        .fifo_out_full  (fifo_out_full),
        .fifo_out_w_en  (fifo_out_w_en),
        .fifo_out_wdata (fifo_out_wdata),
`ifdef ALU_SEQ_PERF_CNT_EN
        .ops_done       (ops_done),
`endif
        .busy           (busy),
        .err_timeout    (err_timeout)
    );

    // ---------------- FIFO_IN model ----------------
    logic [FIW-1:0] fifo_mem [0:15];
    int wp = 0;
    int rp = 0;
    assign fifo_in_empty = (wp == rp);

    initial fifo_in_rdata = '0;
    always @(posedge clk) begin
        if (fifo_in_r_en) begin
            fifo_in_rdata <= fifo_mem[rp[3:0]];
            rp            <= rp + 1;
        end
    end

    task automatic push(input logic [1:0] op, input logic [11:0] d1, input logic [11:0] d0);
        fifo_mem[wp[3:0]] = {op, d1, d0};
        wp = wp + 1;
    endtask

    // ---------------- ALU model ----------------
    // done is raised alu_delay cycles after the start cycle.
    int alu_delay = 2;
    bit alu_never = 1'b0;
    int alu_cd    = 0;
    initial alu_result = '0;
    assign alu_done = (alu_cd == 1);
    always @(posedge clk) begin
        if (alu_start && !alu_never) begin
            alu_cd     <= alu_delay;
            alu_result <= (alu_op == 2'b01) ? (24'(alu_a) + 24'(alu_b))
                                            : (24'(alu_a) * 24'(alu_b));
        end else if (alu_cd > 0) begin
            alu_cd <= alu_cd - 1;
        end
    end

    // ---------------- monitors ----------------
    int cyc = 0;
    int pop_cnt = 0, start_cnt = 0, wen_cnt = 0, done_cnt = 0;
    int pop_cyc = 0, start_cyc = 0, wen_cyc = 0, done_cyc = 0;
    int pop_empty_err = 0, wfull_err = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_in_r_en) begin
            pop_cnt <= pop_cnt + 1;
            pop_cyc <= cyc;
            if (wp == rp) pop_empty_err <= pop_empty_err + 1;
        end
        if (alu_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
        if (alu_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (fifo_out_w_en) begin
            wen_cnt <= wen_cnt + 1;
            wen_cyc <= cyc;
            if (fifo_out_full) wfull_err <= wfull_err + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_wen(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (fifo_out_w_en) seen = 1'b1;
        end
        if (!seen) check({tag, "_wen_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_start(input string tag, input int budget);
        int s0 = start_cnt;
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (start_cnt != s0) seen = 1'b1;
        end
        if (!seen) check({tag, "_start_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = done_cnt;
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done_cnt != d0) seen = 1'b1;
        end
        if (!seen) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int p0, w0, s0;

    initial begin
        rst_n         = 1'b0;
        enable        = 1'b0;
        err_clr       = 1'b0;
        fifo_out_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // ---- reset state ----
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_ren",   32'(fifo_in_r_en), 32'd0);
        check("rst_start", 32'(alu_start), 32'd0);
        check("rst_wen",   32'(fifo_out_w_en), 32'd0);
        check("rst_err",   32'(err_timeout), 32'd0);
        check("rst_op",    32'(alu_op), 32'd0);
        check("rst_a",     32'(alu_a), 32'd0);
        check("rst_b",     32'(alu_b), 32'd0);
        check("rst_wdata", 32'(fifo_out_wdata), 32'd0);
`ifdef ALU_SEQ_PERF_CNT_EN
        check("rst_ops_done", 32'(ops_done), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // ---- add: data1=5, data0=7 -> 12 ----
        w0 = wen_cnt;
        alu_delay = 2;
        push(2'b01, 12'd5, 12'd7);
        enable = 1'b1;
        wait_wen("add", 40);
        check("add_wdata", 32'(fifo_out_wdata), 32'h000000C);
        @(negedge clk);
        check("add_wen_count",  32'(wen_cnt - w0), 32'd1);
        check("add_start_lat",  32'(start_cyc - pop_cyc), 32'd2);
        check("add_done_to_wen", 32'(wen_cyc - done_cyc), 32'd1);
        check("add_a",  32'(alu_a), 32'd7);
        check("add_b",  32'(alu_b), 32'd5);
        check("add_op", 32'(alu_op), 32'd1);

        // ---- illegal opcode ----
        s0 = start_cnt;
        push(2'b11, 12'd3, 12'd4);
        wait_wen("illegal", 40);
        check("illegal_wdata", 32'(fifo_out_wdata), 32'h1000000);
        check("illegal_err",   32'(err_timeout), 32'd0);
        @(negedge clk);
        check("illegal_no_start", 32'(start_cnt - s0), 32'd0);

        // ---- multiply, done on the last allowed WAIT cycle (done wins) ----
        alu_delay = 16;
        push(2'b10, 12'd50, 12'd100);
        wait_wen("mul_edge", 60);
        check("mul_edge_wdata", 32'(fifo_out_wdata), 32'd5000);
        check("mul_edge_err",   32'(err_timeout), 32'd0);
        @(negedge clk);
        check("mul_edge_lat", 32'(wen_cyc - start_cyc), 32'd17);

        // ---- timeout ----
        alu_never = 1'b1;
        push(2'b01, 12'd1, 12'd1);
        wait_wen("timeout", 60);
        check("timeout_wdata", 32'(fifo_out_wdata), 32'h1000000);
        check("timeout_err",   32'(err_timeout), 32'd1);
        @(negedge clk);
        check("timeout_lat", 32'(wen_cyc - start_cyc), 32'd17);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("timeout_err_clr", 32'(err_timeout), 32'd0);

        // ---- timeout coinciding with err_clr: timeout wins ----
        err_clr = 1'b1;
        push(2'b01, 12'd1, 12'd1);
        wait_wen("to_vs_clr", 60);
        check("to_vs_clr_err", 32'(err_timeout), 32'd1);
        err_clr   = 1'b0;
        alu_never = 1'b0;
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // ---- backpressure ----
        alu_delay     = 2;
        fifo_out_full = 1'b1;
        p0 = pop_cnt;
        w0 = wen_cnt;
        push(2'b01, 12'd1, 12'd2);
        push(2'b01, 12'd4, 12'd5);
        wait_done("bp", 40);
        check("bp_wdata", 32'(fifo_out_wdata), 32'd3);
        repeat (3) @(negedge clk);
        check("bp_hold_wdata", 32'(fifo_out_wdata), 32'd3);
        check("bp_no_wen",     32'(fifo_out_w_en), 32'd0);
        check("bp_wen_count",  32'(wen_cnt - w0), 32'd0);
        check("bp_no_pop2",    32'(pop_cnt - p0), 32'd1);
        check("bp_busy",       32'(busy), 32'd1);
        fifo_out_full = 1'b0;
        @(negedge clk);
        check("bp_release", 32'(wen_cnt - w0), 32'd1);
        wait_wen("bp_second", 40);
        check("bp_second_wdata", 32'(fifo_out_wdata), 32'd9);
        @(negedge clk);

        // ---- enable drop during WAIT ----
        alu_delay = 4;
        p0 = pop_cnt;
        w0 = wen_cnt;
        push(2'b01, 12'd10, 12'd20);
        push(2'b01, 12'd30, 12'd40);
        wait_start("endrop", 40);
        enable = 1'b0;
        wait_wen("endrop_first", 40);
        check("endrop_wdata", 32'(fifo_out_wdata), 32'd30);
        repeat (4) @(negedge clk);
        check("endrop_busy", 32'(busy), 32'd0);
        check("endrop_pops", 32'(pop_cnt - p0), 32'd1);
        check("endrop_wens", 32'(wen_cnt - w0), 32'd1);
        enable = 1'b1;
        wait_wen("endrop_second", 40);
        check("endrop_second_wdata", 32'(fifo_out_wdata), 32'd70);
        @(negedge clk);

        // ---- reset mid-WAIT ----
        alu_never = 1'b1;
        w0 = wen_cnt;
        push(2'b01, 12'd2, 12'd2);
        wait_start("rstmid", 40);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_busy",  32'(busy), 32'd0);
        check("rstmid_op",    32'(alu_op), 32'd0);
        check("rstmid_a",     32'(alu_a), 32'd0);
        check("rstmid_b",     32'(alu_b), 32'd0);
        check("rstmid_wdata", 32'(fifo_out_wdata), 32'd0);
        check("rstmid_wen",   32'(fifo_out_w_en), 32'd0);
`ifdef ALU_SEQ_PERF_CNT_EN
        check("rstmid_ops_done", 32'(ops_done), 32'd0);
`endif
        rst_n     = 1'b1;
        alu_never = 1'b0;
        repeat (25) @(negedge clk);
        check("rstmid_no_write", 32'(wen_cnt - w0), 32'd0);
        check("rstmid_idle",     32'(busy), 32'd0);

        // ---- FIFO protocol over the whole run ----
        check("pop_while_empty",  32'(pop_empty_err), 32'd0);
        check("write_while_full", 32'(wfull_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_op_sequencer
`default_nettype wire
